// File: rtl/reg_bus_mux_if.sv
// Bus-mux interface: source data/enables and control in, selected bus and debug state out.
interface reg_bus_mux_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N_SRC = 24,
   parameter int unsigned IDXW  = (N_SRC > 1) ? $clog2(N_SRC) : 1
);
   logic [N_SRC*WIDTH-1:0] src_data;
   logic [N_SRC-1:0]       src_out;
   logic                   stall;
   logic                   err_clr;
   logic [WIDTH-1:0]       bus_comb;
   logic [WIDTH-1:0]       bus_out;
   logic                   bus_valid;
   logic [IDXW-1:0]        bus_src;
   logic                   conflict;
   logic [7:0]             conflict_cnt;

   // Side that drives the sources and consumes the bus
   modport master (
      output src_data, src_out, stall, err_clr,
      input  bus_comb, bus_out, bus_valid, bus_src, conflict, conflict_cnt
   );

   // The multiplexer itself
   modport slave (
      input  src_data, src_out, stall, err_clr,
      output bus_comb, bus_out, bus_valid, bus_src, conflict, conflict_cnt
   );
endinterface

// File: rtl/reg_bus_mux.sv
// Registered one-hot bus multiplexer with hold, conflict detection and debug counters.
module reg_bus_mux #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned N_SRC  = 24,
   parameter int unsigned STRICT = 0,
   parameter int unsigned IDXW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input logic         clock,
   input logic         clear,
   reg_bus_mux_if.slave bus
);

   logic [WIDTH-1:0] bus_out_q, bus_out_d;
   logic [IDXW-1:0]  bus_src_q, bus_src_d;
   logic             bus_valid_q, bus_valid_d;
   logic             conflict_q, conflict_d;
   logic [7:0]       conflict_cnt_q, conflict_cnt_d;

   logic             found;
   logic             multi;
   logic [IDXW-1:0]  win_idx;
   logic [WIDTH-1:0] win_data;
   logic             capture;

   // Priority search: lowest asserted enable wins, a second hit flags a conflict
   always_comb begin
      found    = 1'b0;
      multi    = 1'b0;
      win_idx  = '0;
      win_data = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (bus.src_out[i]) begin
            if (found) begin
               multi = 1'b1;
            end else begin
               found    = 1'b1;
               win_idx  = IDXW'(i);
               win_data = bus.src_data[i*WIDTH +: WIDTH];
            end
         end
      end
      // Strict mode refuses to pick a winner when several sources drive
      capture = found && (!multi || (STRICT == 0));
   end

   // Next-state for bus register and conflict bookkeeping
   always_comb begin
      bus_out_d      = bus_out_q;
      bus_src_d      = bus_src_q;
      bus_valid_d    = bus_valid_q;
      conflict_d     = conflict_q;
      conflict_cnt_d = conflict_cnt_q;

      if (!bus.stall) begin
         bus_valid_d = capture;
         if (capture) begin
            bus_out_d = win_data;
            bus_src_d = win_idx;
         end
      end

      // Conflicts are tracked even while stalled; a clear coincident with a
      // conflict restarts the count at one so the event is not lost
      if (multi) begin
         conflict_d = 1'b1;
         if (bus.err_clr) begin
            conflict_cnt_d = 8'd1;
         end else if (conflict_cnt_q != 8'hFF) begin
            conflict_cnt_d = conflict_cnt_q + 8'd1;
         end
      end else if (bus.err_clr) begin
         conflict_d     = 1'b0;
         conflict_cnt_d = 8'd0;
      end
   end

   // State registers with synchronous clear
   always_ff @(posedge clock) begin
      if (clear) begin
         bus_out_q      <= '0;
         bus_src_q      <= '0;
         bus_valid_q    <= 1'b0;
         conflict_q     <= 1'b0;
         conflict_cnt_q <= 8'd0;
      end else begin
         bus_out_q      <= bus_out_d;
         bus_src_q      <= bus_src_d;
         bus_valid_q    <= bus_valid_d;
         conflict_q     <= conflict_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign bus.bus_comb     = capture ? win_data : bus_out_q;
   assign bus.bus_out      = bus_out_q;
   assign bus.bus_src      = bus_src_q;
   assign bus.bus_valid    = bus_valid_q;
   assign bus.conflict     = conflict_q;
   assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: doc/reg_bus_mux.md
# reg_bus_mux

Parametrised, registered successor to the datapath bus multiplexer: selects one of `N_SRC` sources of `WIDTH` bits from one-hot drive enables. It provides the same-cycle bus value for the existing single-cycle datapath and a registered copy for pipelined consumers. It holds the last driven value when no source drives, detects multi-driver conflicts, and keeps a sticky conflict flag, a saturating conflict counter and the index of the last captured source for debug. It sits between the register file/special registers and all bus consumers (MAR, MDR, Y, IR, register inputs).

## Interface
Parameters:
- `WIDTH`, 32, data width of every source and of the bus
- `N_SRC`, 24, number of sources
- `STRICT`, 0, conflict mode:
  - 0: lowest asserted index wins.
  - 1: a conflicting cycle captures nothing.
- `IDXW`, `$clog2(N_SRC)`, width of the source-index output

Ports:
- `clock`  in  1  single clock, all state updates on rising edge
- `clear`  in  1  synchronous, active-high reset
- `src_data`  in  `N_SRC*WIDTH`  flattened sources; source i at `[i*WIDTH +: WIDTH]`
- `src_out`  in  `N_SRC`  drive enables; bit i = source i drives the bus
- `stall`  in  1  freezes the bus register, `bus_src` and `bus_valid`
- `err_clr`  in  1  clears `conflict` and `conflict_cnt`
- `bus_comb`  out  `WIDTH`  same-cycle selected value (combinational)
- `bus_out`  out  `WIDTH`  registered bus value
- `bus_valid`  out  1  registered; 1 if a source was captured on the last non-stalled edge
- `bus_src`  out  `IDXW`  index of the last captured source
- `conflict`  out  1  sticky multi-driver flag
- `conflict_cnt`  out  8  number of conflicting cycles, saturates at 255

## Operation
- Driver count: `n` = popcount(`src_out`). A conflict is any cycle with `n`>1.
- Winner is the lowest asserted index.
- Capture condition:
  - `n`==1: capture.
  - `n`>1 and `STRICT`=0: capture.
  - `n`>1 and `STRICT`=1: no capture.
  - `n`==0: no capture.
- `bus_comb` = winner's data when the capture condition holds, else `bus_out` (held value). No latch is inferred.
- Rising edge, `stall`=0:
  - Capture: `bus_out`←winner data, `bus_src`←winner index, `bus_valid`←1.
  - No capture: `bus_out` and `bus_src` hold, `bus_valid`←0.
- `stall`=1: `bus_out`, `bus_src` and `bus_valid` hold. Conflict detection and counting continue regardless of `stall`.
- Conflict bookkeeping on each edge:
  - `err_clr`=1 with no conflict: `conflict`←0, `conflict_cnt`←0.
  - `err_clr`=1 with a conflict: `conflict`←1, `conflict_cnt`←1 (clear applies first, then the event is counted; no event is lost).
  - `err_clr`=0 with a conflict: `conflict`←1, `conflict_cnt`←min(cnt+1, 255).
  - Otherwise `conflict` and `conflict_cnt` hold.
- Width rules: `conflict_cnt` never wraps. `bus_src` is always < `N_SRC`.

## Timing
- `clear` sampled at the rising edge and dominates `stall`, `err_clr` and all sources. The next cycle shows `bus_out`=0, `bus_valid`=0, `bus_src`=0, `conflict`=0, `conflict_cnt`=0, and `bus_comb`=0 if nothing drives.
- `clear` mid-operation discards the in-flight capture and any conflict seen in that same cycle.
- `bus_comb`: 0-cycle latency from `src_out`/`src_data`.
- `bus_out`, `bus_src`, `bus_valid`: 1-cycle latency after an edge where `stall`=0.
- `conflict` and `conflict_cnt`: updated on the edge that ends the conflicting cycle, visible the next cycle.
- Back-to-back captures every cycle are supported with no bubbles.
- `stall` released: the first edge with `stall`=0 captures that cycle's sources. Nothing captured during the stall is replayed.

## Test plan
- Reset/hold: `clear` 1 cycle, then `src_out`=0 for 3 cycles:
  - `bus_out`=0, `bus_valid`=0, `bus_comb`=0 and `conflict_cnt`=0 throughout.
  - Then drive source 5 = 0xDEADBEEF for 1 cycle, then none:
    - `bus_comb`=0xDEADBEEF same cycle.
    - `bus_out`=0xDEADBEEF next cycle and stays there.
    - `bus_valid` high for exactly 1 cycle; `bus_src`=5.
- Priority conflict, `STRICT`=0: sources 3=0x11 and 20=0x22 driven together:
  - `bus_comb`=0x11; next cycle `bus_out`=0x11, `bus_src`=3, `conflict`=1, `conflict_cnt`=1.
- Strict conflict, `STRICT`=1: preload `bus_out`=0xA5A5A5A5 from source 0, then drive sources 1 and 2 together:
  - `bus_comb`=0xA5A5A5A5; `bus_out` unchanged; `bus_valid`=0; `conflict_cnt`=1.
- Saturation and clear: 300 consecutive conflicting cycles:
  - `conflict_cnt`=255, no wrap.
  - `err_clr` with no conflict → 0 next cycle.
  - `err_clr` coincident with a conflict → `conflict_cnt`=1, `conflict`=1.
- Stall: capture 0x1234 from source 7, assert `stall` while source 9 drives 0x5678:
  - `bus_out` stays 0x1234; `bus_comb`=0x5678; `bus_src` stays 7.
  - Release `stall` with source 9 still driving → `bus_out`=0x5678 next cycle.
- Reset mid-stream: `clear` asserted in the same cycle as a conflicting capture:
  - Next cycle all registered outputs are 0, including `conflict_cnt`=0.
